// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg : shared types for the IF/MEM unified-memory arbiter | rev 1.0
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  localparam int ARB_ADDR_W  = 8;
  localparam int ARB_DATA_W  = 32;
  localparam int ARB_TIMEOUT = 64;

  typedef logic [ARB_ADDR_W-1:0] addr_port;
  typedef logic [ARB_DATA_W-1:0] data_port;
  typedef logic [ARB_DATA_W-1:0] inst_port;

  typedef enum logic [1:0] {IDLE, DATA, FETCH, DRAIN} arb_state_t;
  typedef enum logic [0:0] {GRANT_FETCH, GRANT_DATA}  grant_t;

  function automatic grant_t other_side(input grant_t g);
    return (g == GRANT_FETCH) ? GRANT_DATA : GRANT_FETCH;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_wait_timer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// arb_wait_timer : counts cycles spent waiting for mem_ack | rev 1.0
// -----------------------------------------------------------------------------
module arb_wait_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the waiting cycle that brings the count up to TIMEOUT.
  assign expired_o = enable_i && !clear_i && (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mem_port_arbiter : round-robin IF/MEM access to one single-ported memory | rev 1.0
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ARB_ADDR_W,
  parameter int DATA_W  = ARB_DATA_W,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_valid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              branch_flag_i,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_valid_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  arb_state_t        state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              dm_valid_q, dm_valid_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              err_q, err_d;

  logic   w_dm_pend, w_if_pend;
  grant_t w_grant;
  logic   w_tmr_clear, w_tmr_en, w_tmr_expired;

  // A request still high during its own valid cycle has already been served.
  assign w_dm_pend = dm_req_i && !dm_valid_q;
  assign w_if_pend = if_req_i && !if_valid_q && !branch_flag_i;
  assign stall_o   = w_dm_pend || w_if_pend;

  arb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (w_tmr_clear),
    .enable_i (w_tmr_en),
    .expired_o(w_tmr_expired)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_valid_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_valid_d   = 1'b0;
    dm_rdata_d   = dm_rdata_q;
    err_d        = err_q;
    w_tmr_clear  = 1'b0;
    w_tmr_en     = 1'b0;
    w_grant      = GRANT_FETCH;

    if (w_dm_pend && w_if_pend) begin
      w_grant = other_side(last_grant_q);
    end else if (w_dm_pend) begin
      w_grant = GRANT_DATA;
    end

    case (state_q)
      IDLE: begin
        if (w_dm_pend || w_if_pend) begin
          last_grant_d = w_grant;
          mem_req_d    = 1'b1;
          w_tmr_clear  = 1'b1;
          if (w_grant == GRANT_DATA) begin
            state_d     = DATA;
            mem_we_d    = dm_we_i;
            mem_addr_d  = dm_addr_i;
            mem_wdata_d = dm_wdata_i;
          end else begin
            state_d    = FETCH;
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr_i;
          end
        end
      end
      DATA: begin
        w_tmr_en = 1'b1;
        if (mem_ack_i) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          dm_valid_d = 1'b1;
          if (!mem_we_q) dm_rdata_d = mem_rdata_i;
        end else if (w_tmr_expired) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          err_d      = 1'b1;
          dm_valid_d = 1'b1;
          dm_rdata_d = '0;
        end
      end
      FETCH: begin
        w_tmr_en = 1'b1;
        if (mem_ack_i) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (!branch_flag_i) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata_i;
          end
        end else if (branch_flag_i) begin
          // The memory cannot be aborted, so keep the request up and discard its reply.
          state_d     = DRAIN;
          w_tmr_clear = 1'b1;
        end else if (w_tmr_expired) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          err_d      = 1'b1;
          if_valid_d = 1'b1;
          if_rdata_d = '0;
        end
      end
      DRAIN: begin
        w_tmr_en = 1'b1;
        if (mem_ack_i) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end else if (w_tmr_expired) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_FETCH;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_valid_q   <= 1'b0;
      if_rdata_q   <= '0;
      dm_valid_q   <= 1'b0;
      dm_rdata_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_valid_q   <= if_valid_d;
      if_rdata_q   <= if_rdata_d;
      dm_valid_q   <= dm_valid_d;
      dm_rdata_q   <= dm_rdata_d;
      err_q        <= err_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_valid_o  = if_valid_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_valid_o  = dm_valid_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign err_o       = err_q;

endmodule
`default_nettype wire
